// File: rtl/cpu7_tlb_arb.sv
// Shares one address translator between the inst-side and data-side TLB ports.
// Requests are captured as pending, granted one at a time, and each result is held until recv.
module cpu7_tlb_arb #(
  parameter int unsigned GRLEN      = 32,
  parameter int unsigned PABITS     = 32,
  parameter int unsigned STREAK_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_tlb_req,
  input  logic [GRLEN-1:0]  inst_tlb_vaddr,
  input  logic              itlb_cache_recv,
  input  logic              data_tlb_req,
  input  logic              data_tlb_wr,
  input  logic [GRLEN-1:0]  data_tlb_vaddr,
  input  logic              dtlb_cache_recv,
  output logic              xl_req,
  output logic [GRLEN-1:0]  xl_vaddr,
  output logic              xl_wr,
  input  logic              xl_ack,
  input  logic [PABITS-1:0] xl_paddr,
  input  logic              xl_hit,
  input  logic              xl_uncache,
  input  logic [5:0]        xl_exccode,
  output logic              itlb_finish,
  output logic [PABITS-1:0] itlb_paddr,
  output logic              itlb_hit,
  output logic              itlb_uncache,
  output logic [5:0]        itlb_exccode,
  output logic              dtlb_finish,
  output logic [PABITS-1:0] dtlb_paddr,
  output logic              dtlb_hit,
  output logic              dtlb_uncache,
  output logic [5:0]        dtlb_exccode
);

  typedef enum logic [1:0] {StIdle, StLookup, StResp} state_e;

  typedef struct packed {
    logic              finish;
    logic [PABITS-1:0] paddr;
    logic              hit;
    logic              uncache;
    logic [5:0]        exccode;
  } res_t;

  state_e            state_q, state_d;
  logic              pend_inst_q, pend_inst_d;
  logic              pend_data_q, pend_data_d;
  logic [GRLEN-1:0]  inst_vaddr_q, inst_vaddr_d;
  logic [GRLEN-1:0]  data_vaddr_q, data_vaddr_d;
  logic              data_wr_q, data_wr_d;
  logic              gnt_data_q, gnt_data_d;
  logic [GRLEN-1:0]  gnt_vaddr_q, gnt_vaddr_d;
  logic              gnt_wr_q, gnt_wr_d;
  logic [1:0]        streak_q, streak_d;
  res_t              itlb_q, itlb_d;
  res_t              dtlb_q, dtlb_d;

  logic inst_cand, data_cand, streak_hit, grant_inst, side_recv;

  // Candidates include this cycle's requests so an idle arbiter grants with no extra cycle.
  assign inst_cand  = pend_inst_q | inst_tlb_req;
  assign data_cand  = pend_data_q | data_tlb_req;
  assign streak_hit = (32'(streak_q) >= STREAK_MAX);
  assign grant_inst = inst_cand & (~data_cand | streak_hit);
  assign side_recv  = gnt_data_q ? dtlb_cache_recv : itlb_cache_recv;

  always_comb begin
    state_d      = state_q;
    pend_inst_d  = pend_inst_q;
    pend_data_d  = pend_data_q;
    inst_vaddr_d = inst_vaddr_q;
    data_vaddr_d = data_vaddr_q;
    data_wr_d    = data_wr_q;
    gnt_data_d   = gnt_data_q;
    gnt_vaddr_d  = gnt_vaddr_q;
    gnt_wr_d     = gnt_wr_q;
    streak_d     = streak_q;
    itlb_d       = itlb_q;
    dtlb_d       = dtlb_q;

    // Newest request always wins the latch, including on the side currently in service.
    if (inst_tlb_req) begin
      pend_inst_d  = 1'b1;
      inst_vaddr_d = inst_tlb_vaddr;
    end
    if (data_tlb_req) begin
      pend_data_d  = 1'b1;
      data_vaddr_d = data_tlb_vaddr;
      data_wr_d    = data_tlb_wr;
    end

    case (state_q)
      StIdle: begin
        if (grant_inst) begin
          pend_inst_d = 1'b0;
          gnt_data_d  = 1'b0;
          gnt_vaddr_d = inst_tlb_req ? inst_tlb_vaddr : inst_vaddr_q;
          gnt_wr_d    = 1'b0;
          streak_d    = '0;
          state_d     = StLookup;
        end else if (data_cand) begin
          pend_data_d = 1'b0;
          gnt_data_d  = 1'b1;
          gnt_vaddr_d = data_tlb_req ? data_tlb_vaddr : data_vaddr_q;
          gnt_wr_d    = data_tlb_req ? data_tlb_wr : data_wr_q;
          if (inst_cand) begin
            streak_d = (streak_q == 2'd3) ? streak_q : streak_q + 2'd1;
          end else begin
            streak_d = '0;
          end
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (xl_ack) begin
          if (gnt_data_q) begin
            dtlb_d.finish  = 1'b1;
            dtlb_d.paddr   = xl_paddr;
            dtlb_d.hit     = xl_hit;
            dtlb_d.uncache = xl_uncache;
            dtlb_d.exccode = xl_exccode;
          end else begin
            itlb_d.finish  = 1'b1;
            itlb_d.paddr   = xl_paddr;
            itlb_d.hit     = xl_hit;
            itlb_d.uncache = xl_uncache;
            itlb_d.exccode = xl_exccode;
          end
          state_d = StResp;
        end
      end
      StResp: begin
        if (side_recv) begin
          itlb_d.finish = 1'b0;
          dtlb_d.finish = 1'b0;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      pend_inst_q  <= 1'b0;
      pend_data_q  <= 1'b0;
      inst_vaddr_q <= '0;
      data_vaddr_q <= '0;
      data_wr_q    <= 1'b0;
      gnt_data_q   <= 1'b0;
      gnt_vaddr_q  <= '0;
      gnt_wr_q     <= 1'b0;
      streak_q     <= '0;
      itlb_q       <= '0;
      dtlb_q       <= '0;
    end else begin
      state_q      <= state_d;
      pend_inst_q  <= pend_inst_d;
      pend_data_q  <= pend_data_d;
      inst_vaddr_q <= inst_vaddr_d;
      data_vaddr_q <= data_vaddr_d;
      data_wr_q    <= data_wr_d;
      gnt_data_q   <= gnt_data_d;
      gnt_vaddr_q  <= gnt_vaddr_d;
      gnt_wr_q     <= gnt_wr_d;
      streak_q     <= streak_d;
      itlb_q       <= itlb_d;
      dtlb_q       <= dtlb_d;
    end
  end

  // xl_req decodes the state flop directly so reset drops it without waiting for a clock.
  assign xl_req       = (state_q == StLookup);
  assign xl_vaddr     = gnt_vaddr_q;
  assign xl_wr        = gnt_wr_q;

  assign itlb_finish  = itlb_q.finish;
  assign itlb_paddr   = itlb_q.paddr;
  assign itlb_hit     = itlb_q.hit;
  assign itlb_uncache = itlb_q.uncache;
  assign itlb_exccode = itlb_q.exccode;
  assign dtlb_finish  = dtlb_q.finish;
  assign dtlb_paddr   = dtlb_q.paddr;
  assign dtlb_hit     = dtlb_q.hit;
  assign dtlb_uncache = dtlb_q.uncache;
  assign dtlb_exccode = dtlb_q.exccode;

endmodule

// File: tb/tb_cpu7_tlb_arb.sv
// Bench for cpu7_tlb_arb: directed scenarios plus random traffic, all checked against
// a transaction-level model of the arbiter.
module tb_cpu7_tlb_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_tlb_req, itlb_cache_recv, data_tlb_req, data_tlb_wr, dtlb_cache_recv;
  logic [31:0] inst_tlb_vaddr, data_tlb_vaddr;
  logic        xl_req, xl_wr, xl_ack, xl_hit, xl_uncache;
  logic [31:0] xl_vaddr, xl_paddr;
  logic [5:0]  xl_exccode;
  logic        itlb_finish, itlb_hit, itlb_uncache, dtlb_finish, dtlb_hit, dtlb_uncache;
  logic [31:0] itlb_paddr, dtlb_paddr;
  logic [5:0]  itlb_exccode, dtlb_exccode;

  always #5 clk = ~clk;

  cpu7_tlb_arb #(
    .GRLEN(32),
    .PABITS(32),
    .STREAK_MAX(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .inst_tlb_req(inst_tlb_req),
    .inst_tlb_vaddr(inst_tlb_vaddr),
    .itlb_cache_recv(itlb_cache_recv),
    .data_tlb_req(data_tlb_req),
    .data_tlb_wr(data_tlb_wr),
    .data_tlb_vaddr(data_tlb_vaddr),
    .dtlb_cache_recv(dtlb_cache_recv),
    .xl_req(xl_req),
    .xl_vaddr(xl_vaddr),
    .xl_wr(xl_wr),
    .xl_ack(xl_ack),
    .xl_paddr(xl_paddr),
    .xl_hit(xl_hit),
    .xl_uncache(xl_uncache),
    .xl_exccode(xl_exccode),
    .itlb_finish(itlb_finish),
    .itlb_paddr(itlb_paddr),
    .itlb_hit(itlb_hit),
    .itlb_uncache(itlb_uncache),
    .itlb_exccode(itlb_exccode),
    .dtlb_finish(dtlb_finish),
    .dtlb_paddr(dtlb_paddr),
    .dtlb_hit(dtlb_hit),
    .dtlb_uncache(dtlb_uncache),
    .dtlb_exccode(dtlb_exccode)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: who is being served (0 none, 1 inst, 2 data), whether the translator
  // answer is still outstanding, per-side pending requests, and the data-win run length.
  bit          m_pi, m_pd, m_wd, m_wait;
  logic [31:0] m_vi, m_vd;
  int          m_srv, m_run;
  bit          e_req, e_wr, e_if, e_df, e_ihit, e_iunc, e_dhit, e_dunc;
  logic [31:0] e_va, e_ipa, e_dpa;
  logic [5:0]  e_iexc, e_dexc;

  task automatic model_reset();
    m_pi = 0; m_pd = 0; m_wd = 0; m_wait = 0; m_vi = 0; m_vd = 0; m_srv = 0; m_run = 0;
    e_req = 0; e_wr = 0; e_va = 0;
    e_if = 0; e_ipa = 0; e_ihit = 0; e_iunc = 0; e_iexc = 0;
    e_df = 0; e_dpa = 0; e_dhit = 0; e_dunc = 0; e_dexc = 0;
  endtask

  // Applies one rising edge using the inputs that were present before it.
  task automatic model_edge();
    bit was_idle;
    bit recv;
    if (reset) begin
      model_reset();
      return;
    end
    was_idle = (m_srv == 0);
    if (!was_idle && m_wait) begin
      if (xl_ack) begin
        if (m_srv == 2) begin
          e_df = 1; e_dpa = xl_paddr; e_dhit = xl_hit; e_dunc = xl_uncache; e_dexc = xl_exccode;
        end else begin
          e_if = 1; e_ipa = xl_paddr; e_ihit = xl_hit; e_iunc = xl_uncache; e_iexc = xl_exccode;
        end
        m_wait = 0;
      end
    end else if (!was_idle) begin
      recv = (m_srv == 2) ? dtlb_cache_recv : itlb_cache_recv;
      if (recv) begin
        e_if = 0; e_df = 0; m_srv = 0;
      end
    end
    if (inst_tlb_req) begin m_pi = 1; m_vi = inst_tlb_vaddr; end
    if (data_tlb_req) begin m_pd = 1; m_vd = data_tlb_vaddr; m_wd = data_tlb_wr; end
    if (was_idle && (m_pi || m_pd)) begin
      if (m_pi && (!m_pd || m_run >= 3)) begin
        m_srv = 1; e_va = m_vi; e_wr = 0; m_pi = 0; m_run = 0;
      end else begin
        m_srv = 2; e_va = m_vd; e_wr = m_wd; m_pd = 0;
        m_run = m_pi ? m_run + 1 : 0;
      end
      m_wait = 1;
    end
    e_req = (m_srv != 0) && m_wait;
  endtask

  task automatic compare_all();
    check("xl_req", 32'(xl_req), 32'(e_req));
    check("xl_vaddr", xl_vaddr, e_va);
    check("xl_wr", 32'(xl_wr), 32'(e_wr));
    check("itlb_finish", 32'(itlb_finish), 32'(e_if));
    check("itlb_paddr", itlb_paddr, e_ipa);
    check("itlb_hit", 32'(itlb_hit), 32'(e_ihit));
    check("itlb_uncache", 32'(itlb_uncache), 32'(e_iunc));
    check("itlb_exccode", 32'(itlb_exccode), 32'(e_iexc));
    check("dtlb_finish", 32'(dtlb_finish), 32'(e_df));
    check("dtlb_paddr", dtlb_paddr, e_dpa);
    check("dtlb_hit", 32'(dtlb_hit), 32'(e_dhit));
    check("dtlb_uncache", 32'(dtlb_uncache), 32'(e_dunc));
    check("dtlb_exccode", 32'(dtlb_exccode), 32'(e_dexc));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    compare_all();
  endtask

  task automatic idle_inputs();
    inst_tlb_req = 0; inst_tlb_vaddr = 0; itlb_cache_recv = 0;
    data_tlb_req = 0; data_tlb_wr = 0; data_tlb_vaddr = 0; dtlb_cache_recv = 0;
    xl_ack = 0; xl_paddr = 0; xl_hit = 0; xl_uncache = 0; xl_exccode = 0;
  endtask

  // Zero-wait translator and eager caches until everything outstanding has drained.
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      inst_tlb_req = 0; data_tlb_req = 0;
      xl_ack = xl_req; xl_paddr = $urandom;
      itlb_cache_recv = itlb_finish; dtlb_cache_recv = dtlb_finish;
    end
    idle_inputs();
    step();
  endtask

  initial begin
    int  ngr;
    bit  found;
    model_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    check("rst_xl_req", 32'(xl_req), 32'd0);
    check("rst_itlb_finish", 32'(itlb_finish), 32'd0);
    check("rst_dtlb_finish", 32'(dtlb_finish), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'd0);
    reset = 0;
    step();

    // Single data request with a next-cycle translator answer.
    data_tlb_req = 1; data_tlb_vaddr = 32'h1C00_1234; data_tlb_wr = 1;
    step();
    check("single_xl_req", 32'(xl_req), 32'd1);
    check("single_xl_wr", 32'(xl_wr), 32'd1);
    data_tlb_req = 0; xl_ack = 1; xl_paddr = 32'h0000_1234; xl_hit = 1;
    step();
    xl_ack = 0;
    check("single_dfinish", 32'(dtlb_finish), 32'd1);
    check("single_dpaddr", dtlb_paddr, 32'h0000_1234);
    for (int i = 0; i < 3; i++) begin
      step();
      check("single_hold", 32'(dtlb_finish), 32'd1);
      check("single_ifinish", 32'(itlb_finish), 32'd0);
    end
    dtlb_cache_recv = 1;
    step();
    dtlb_cache_recv = 0;
    check("single_drop", 32'(dtlb_finish), 32'd0);

    // Simultaneous requests: data first, inst at T+4/T+5.
    inst_tlb_req = 1; inst_tlb_vaddr = 32'h1C00_0000;
    data_tlb_req = 1; data_tlb_vaddr = 32'h8000_0010; data_tlb_wr = 0;
    step();
    check("simul_t1_vaddr", xl_vaddr, 32'h8000_0010);
    inst_tlb_req = 0; data_tlb_req = 0; xl_ack = 1; xl_paddr = 32'h0000_0010;
    step();
    check("simul_t2_dfinish", 32'(dtlb_finish), 32'd1);
    xl_ack = 0; dtlb_cache_recv = 1;
    step();
    dtlb_cache_recv = 0;
    check("simul_t3_xl_req", 32'(xl_req), 32'd0);
    step();
    check("simul_t4_xl_req", 32'(xl_req), 32'd1);
    check("simul_t4_vaddr", xl_vaddr, 32'h1C00_0000);
    xl_ack = 1; xl_paddr = 32'h0000_0000;
    step();
    xl_ack = 0;
    check("simul_t5_ifinish", 32'(itlb_finish), 32'd1);
    itlb_cache_recv = 1;
    step();
    itlb_cache_recv = 0;

    // Starvation guard: data requests every cycle while inst waits.
    ngr = 0; found = 0;
    inst_tlb_req = 1; inst_tlb_vaddr = 32'h1C00_0040;
    data_tlb_req = 1; data_tlb_vaddr = 32'h8000_0040; data_tlb_wr = 1;
    for (int c = 0; c < 60 && !found; c++) begin
      step();
      inst_tlb_req = 0;
      if (xl_req) begin
        if (xl_vaddr == 32'h1C00_0040) begin
          found = 1;
          check("starve_streak", 32'(dut.streak_q), 32'd0);
        end else begin
          ngr++;
        end
      end
      xl_ack = xl_req; itlb_cache_recv = itlb_finish; dtlb_cache_recv = dtlb_finish;
    end
    check("starve_inst_granted", 32'(found), 32'd1);
    check("starve_data_grants", 32'(ngr), 32'd3);
    data_tlb_req = 0;
    drain(12);

    // Translator stall with an exception result.
    data_tlb_req = 1; data_tlb_vaddr = 32'h9000_0F00; data_tlb_wr = 0;
    step();
    data_tlb_req = 0;
    for (int i = 0; i < 5; i++) begin
      check("stall_req", 32'(xl_req), 32'd1);
      check("stall_vaddr", xl_vaddr, 32'h9000_0F00);
      step();
    end
    check("stall_req", 32'(xl_req), 32'd1);
    check("stall_vaddr", xl_vaddr, 32'h9000_0F00);
    xl_ack = 1; xl_exccode = 6'h3F; xl_hit = 0; xl_paddr = 32'h0000_0F00;
    step();
    xl_ack = 0;
    check("stall_dfinish", 32'(dtlb_finish), 32'd1);
    check("stall_exccode", 32'(dtlb_exccode), 32'h3F);
    check("stall_hit", 32'(dtlb_hit), 32'd0);
    dtlb_cache_recv = 1;
    step();
    dtlb_cache_recv = 0;

    // Two inst requests while data sits in RESP: only the newer one is translated.
    data_tlb_req = 1; data_tlb_vaddr = 32'h8000_1000;
    step();
    data_tlb_req = 0; xl_ack = 1;
    step();
    xl_ack = 0;
    inst_tlb_req = 1; inst_tlb_vaddr = 32'h1C00_0100;
    step();
    inst_tlb_vaddr = 32'h1C00_0200;
    step();
    inst_tlb_req = 0; dtlb_cache_recv = 1;
    step();
    dtlb_cache_recv = 0;
    step();
    check("ovw_xl_req", 32'(xl_req), 32'd1);
    check("ovw_vaddr", xl_vaddr, 32'h1C00_0200);
    drain(6);

    // Reset during LOOKUP, then a late ack.
    data_tlb_req = 1; data_tlb_vaddr = 32'h8000_2000;
    step();
    data_tlb_req = 0;
    check("rstmid_req_before", 32'(xl_req), 32'd1);
    #2;
    reset = 1;
    model_reset();
    #1;
    check("rstmid_xl_req", 32'(xl_req), 32'd0);
    check("rstmid_xl_vaddr", xl_vaddr, 32'd0);
    check("rstmid_dfinish", 32'(dtlb_finish), 32'd0);
    check("rstmid_ifinish", 32'(itlb_finish), 32'd0);
    step();
    reset = 0; xl_ack = 1; xl_paddr = 32'hDEAD_0000; xl_hit = 1;
    step();
    xl_ack = 0;
    step();
    check("rstmid_late_ack", 32'(dtlb_finish), 32'd0);
    check("rstmid_state", 32'(dut.state_q), 32'd0);

    // Random traffic, including acks and recvs at arbitrary times.
    for (int i = 0; i < 2000; i++) begin
      inst_tlb_req    = ($urandom_range(0, 3) == 0);
      inst_tlb_vaddr  = $urandom;
      data_tlb_req    = ($urandom_range(0, 3) == 0);
      data_tlb_vaddr  = $urandom;
      data_tlb_wr     = 1'($urandom_range(0, 1));
      xl_ack          = xl_req ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      xl_paddr        = $urandom;
      xl_hit          = 1'($urandom_range(0, 1));
      xl_uncache      = 1'($urandom_range(0, 1));
      xl_exccode      = 6'($urandom);
      itlb_cache_recv = ($urandom_range(0, 2) == 0);
      dtlb_cache_recv = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
